// File: rtl/global_defs.sv
// Global matrix geometry shared by the MPU blocks.
package global_defs;

    localparam int M     = 3;
    localparam int N     = 3;
    localparam int MBITS = $clog2(M);
    localparam int NBITS = $clog2(N);

endpackage

// File: rtl/mpu_data_types.sv
// Data types shared by the MPU blocks: the single-precision word and dispatcher states.
package mpu_data_types;

    typedef logic [31:0] float_sp;

    typedef enum logic [1:0] {
        DISPATCH_IDLE,
        DISPATCH_LOAD,
        DISPATCH_FEED,
        DISPATCH_DONE
    } dispatcher_state_e;

endpackage

// File: rtl/mpu_dispatcher.sv
// Loads A and B from the register file into local buffers, then streams column k of A
// and row k of B to the compute cluster for k = 0..N-1.
module mpu_dispatcher
    import global_defs::*;
    import mpu_data_types::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    output logic             dispatcher_busy_out,
    output logic             dispatcher_finished_out,
    output logic [MBITS:0]   reg_dispatch_i_out,
    output logic [NBITS:0]   reg_dispatch_j_out,
    output logic             reg_dispatch_sel_out,
    output logic             reg_dispatch_read_out,
    input  float_sp          reg_dispatch_element_in,
    output float_sp          a_0_out,
    output float_sp          a_1_out,
    output float_sp          a_2_out,
    output float_sp          b_0_out,
    output float_sp          b_1_out,
    output float_sp          b_2_out,
    output logic             feed_valid_out,
    output logic [1:0]       feed_k_out,
    input  logic             cluster_stall_in,
    output logic             error_detected_out
);

    localparam logic [MBITS:0] I_LAST = (MBITS + 1)'(M - 1);
    localparam logic [NBITS:0] J_LAST = (NBITS + 1)'(N - 1);
    localparam logic [1:0]     K_LAST = 2'(N - 1);

    dispatcher_state_e state_q;

    logic             read_q;
    logic             sel_q;
    logic [MBITS:0]   i_q;
    logic [NBITS:0]   j_q;

    logic             cap_valid_q;
    logic             cap_sel_q;
    logic [MBITS-1:0] cap_i_q;
    logic [NBITS-1:0] cap_j_q;

    float_sp          buf_a_q [M][N];
    float_sp          buf_b_q [M][N];
    float_sp          a_q [M];
    float_sp          b_q [N];

    logic             feed_valid_q;
    logic [1:0]       feed_k_q;
    logic             finished_q;
    logic             error_q;

    logic             accept;
    logic [1:0]       k_d;

    always_comb begin
        accept = feed_valid_q && !cluster_stall_in;
        k_d    = feed_k_q + 2'd1;
    end

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order within the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DISPATCH_IDLE;
            read_q       <= 1'b0;
            sel_q        <= 1'b0;
            i_q          <= '0;
            j_q          <= '0;
            cap_valid_q  <= 1'b0;
            cap_sel_q    <= 1'b0;
            cap_i_q      <= '0;
            cap_j_q      <= '0;
            feed_valid_q <= 1'b0;
            feed_k_q     <= '0;
            finished_q   <= 1'b0;
            error_q      <= 1'b0;
            // NOTE: the operand buffers are small flop arrays, not RAM, so clearing
            // them on reset is cheap and keeps stale matrices from leaking into a new run.
            for (int r = 0; r < M; r++) begin
                a_q[r] <= '0;
                for (int c = 0; c < N; c++) begin
                    buf_a_q[r][c] <= '0;
                    buf_b_q[r][c] <= '0;
                end
            end
            for (int c = 0; c < N; c++) b_q[c] <= '0;
        end else begin
            // Read data returns one cycle after the strobe, so the address is delayed to match.
            cap_valid_q <= read_q;
            cap_sel_q   <= sel_q;
            cap_i_q     <= i_q[MBITS-1:0];
            cap_j_q     <= j_q[NBITS-1:0];
            if (cap_valid_q) begin
                if (cap_sel_q) buf_b_q[cap_i_q][cap_j_q] <= reg_dispatch_element_in;
                else           buf_a_q[cap_i_q][cap_j_q] <= reg_dispatch_element_in;
            end

            if (start_in && state_q != DISPATCH_IDLE) error_q <= 1'b1;
            finished_q <= 1'b0;

            case (state_q)
                DISPATCH_IDLE: begin
                    if (start_in) begin
                        state_q <= DISPATCH_LOAD;
                        read_q  <= 1'b1;
                    end
                end
                DISPATCH_LOAD: begin
                    if (read_q) begin
                        if (j_q == J_LAST) begin
                            j_q <= '0;
                            if (i_q == I_LAST) begin
                                i_q   <= '0;
                                sel_q <= !sel_q;
                                if (sel_q) read_q <= 1'b0;
                            end else begin
                                i_q <= i_q + 1'b1;
                            end
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end else begin
                        // Final element is being captured this cycle; it is first needed at k = N-1.
                        state_q      <= DISPATCH_FEED;
                        feed_valid_q <= 1'b1;
                        feed_k_q     <= '0;
                        for (int r = 0; r < M; r++) a_q[r] <= buf_a_q[r][0];
                        for (int c = 0; c < N; c++) b_q[c] <= buf_b_q[0][c];
                    end
                end
                DISPATCH_FEED: begin
                    if (accept) begin
                        if (feed_k_q == K_LAST) begin
                            state_q      <= DISPATCH_DONE;
                            feed_valid_q <= 1'b0;
                            feed_k_q     <= '0;
                            finished_q   <= 1'b1;
                            for (int r = 0; r < M; r++) a_q[r] <= '0;
                            for (int c = 0; c < N; c++) b_q[c] <= '0;
                        end else begin
                            feed_k_q <= k_d;
                            for (int r = 0; r < M; r++) a_q[r] <= buf_a_q[r][k_d];
                            for (int c = 0; c < N; c++) b_q[c] <= buf_b_q[k_d][c];
                        end
                    end
                end
                DISPATCH_DONE: state_q <= DISPATCH_IDLE;
                default:       state_q <= DISPATCH_IDLE;
            endcase
        end
    end

    // Valid is masked by the same-cycle stall so a refused beat is never shown as valid.
    assign feed_valid_out          = feed_valid_q && !cluster_stall_in;
    assign feed_k_out              = feed_k_q;
    assign dispatcher_busy_out     = (state_q != DISPATCH_IDLE);
    assign dispatcher_finished_out = finished_q;
    assign error_detected_out      = error_q;
    assign reg_dispatch_read_out   = read_q;
    assign reg_dispatch_sel_out    = sel_q;
    assign reg_dispatch_i_out      = i_q;
    assign reg_dispatch_j_out      = j_q;
    assign a_0_out                 = a_q[0];
    assign a_1_out                 = a_q[1];
    assign a_2_out                 = a_q[2];
    assign b_0_out                 = b_q[0];
    assign b_1_out                 = b_q[1];
    assign b_2_out                 = b_q[2];

endmodule

// File: tb/tb_mpu_dispatcher.sv
// Directed bench for mpu_dispatcher: A = 1.0..9.0 row-major, B = identity, register file modelled here.
module tb_mpu_dispatcher;
    import mpu_data_types::*;

    localparam float_sp ONE  = 32'h3F80_0000;
    localparam float_sp JUNK = 32'hDEAD_BEEF;

    float_sp a_tab [9] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                           32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000,
                           32'h40E0_0000, 32'h4100_0000, 32'h4110_0000};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_in = 1'b0;
    logic       stall = 1'b0;
    float_sp    elem = '0;
    logic       busy, fin, sel, rd, fv, err;
    logic [2:0] ri, rj;
    logic [1:0] fk;
    float_sp    a_out [3];
    float_sp    b_out [3];

    int vectors = 0;
    int miscompares = 0;

    mpu_dispatcher dut (
        .clk                     (clk),
        .rst                     (rst),
        .start_in                (start_in),
        .dispatcher_busy_out     (busy),
        .dispatcher_finished_out (fin),
        .reg_dispatch_i_out      (ri),
        .reg_dispatch_j_out      (rj),
        .reg_dispatch_sel_out    (sel),
        .reg_dispatch_read_out   (rd),
        .reg_dispatch_element_in (elem),
        .a_0_out                 (a_out[0]),
        .a_1_out                 (a_out[1]),
        .a_2_out                 (a_out[2]),
        .b_0_out                 (b_out[0]),
        .b_1_out                 (b_out[1]),
        .b_2_out                 (b_out[2]),
        .feed_valid_out          (fv),
        .feed_k_out              (fk),
        .cluster_stall_in        (stall),
        .error_detected_out      (err)
    );

    always #5 clk = ~clk;

    // Register file: data for a strobe appears exactly one cycle later, junk otherwise.
    always @(posedge clk) begin
        if (rd === 1'b1)
            elem <= sel ? ((ri == rj) ? ONE : 32'h0) : a_tab[int'(ri) * 3 + int'(rj)];
        else
            elem <= JUNK;
    end

    task automatic test_reset();
        rst = 1'b1; start_in = 1'b0; stall = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || fin !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: got busy=%b fin=%b err=%b want 000", busy, fin, err);
        end
        vectors++;
        if ({rd, sel, ri, rj} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_read: got rd=%b sel=%b i=%0d j=%0d want all 0", rd, sel, ri, rj);
        end
        vectors++;
        if ({fv, fk} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_feed: got valid=%b k=%0d want 0/0", fv, fk);
        end
        vectors++;
        if ({a_out[0], a_out[1], a_out[2], b_out[0], b_out[1], b_out[2]} !== 192'h0) begin
            miscompares++;
            $display("FAIL reset_operands: got a0=%h b2=%h want 0", a_out[0], b_out[2]);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int n, kk;
        logic exp_rd, exp_v, exp_sel;
        logic [2:0] exp_i, exp_j;
        float_sp exp_a, exp_b;
        @(negedge clk);
        start_in = 1'b1;
        for (int t = 1; t <= 25; t++) begin
            @(negedge clk);
            if (t == 1) start_in = 1'b0;
            #1;
            n       = t - 1;
            exp_rd  = (t >= 1 && t <= 18);
            exp_sel = exp_rd ? 1'(n / 9) : 1'b0;
            exp_i   = exp_rd ? 3'((n % 9) / 3) : 3'd0;
            exp_j   = exp_rd ? 3'(n % 3) : 3'd0;
            vectors++;
            if ({rd, sel, ri, rj} !== {exp_rd, exp_sel, exp_i, exp_j}) begin
                miscompares++;
                $display("FAIL basic_read t=%0d: got rd=%b sel=%b i=%0d j=%0d want rd=%b sel=%b i=%0d j=%0d",
                         t, rd, sel, ri, rj, exp_rd, exp_sel, exp_i, exp_j);
            end
            exp_v = (t >= 20 && t <= 22);
            kk    = exp_v ? t - 20 : 0;
            vectors++;
            if ({fv, fk} !== {exp_v, 2'(kk)}) begin
                miscompares++;
                $display("FAIL basic_feed t=%0d: got valid=%b k=%0d want valid=%b k=%0d", t, fv, fk, exp_v, kk);
            end
            for (int r = 0; r < 3; r++) begin
                exp_a = exp_v ? a_tab[r * 3 + kk] : 32'h0;
                exp_b = (exp_v && r == kk) ? ONE : 32'h0;
                vectors++;
                if (a_out[r] !== exp_a || b_out[r] !== exp_b) begin
                    miscompares++;
                    $display("FAIL basic_operand t=%0d idx=%0d: got a=%h b=%h want a=%h b=%h",
                             t, r, a_out[r], b_out[r], exp_a, exp_b);
                end
            end
            vectors++;
            if (fin !== (t == 23) || busy !== (t <= 23)) begin
                miscompares++;
                $display("FAIL basic_done t=%0d: got fin=%b busy=%b want fin=%b busy=%b",
                         t, fin, busy, (t == 23), (t <= 23));
            end
        end
    endtask

    task automatic test_stall();
        int kp;
        logic exp_v;
        float_sp exp_a, exp_b;
        @(negedge clk);
        start_in = 1'b1;
        for (int t = 1; t <= 27; t++) begin
            @(negedge clk);
            if (t == 1) start_in = 1'b0;
            stall = (t == 21 || t == 22);
            #1;
            if (t >= 20 && t <= 24) begin
                kp    = (t == 20) ? 0 : (t == 24) ? 2 : 1;
                exp_v = (t != 21 && t != 22);
                vectors++;
                if ({fv, fk} !== {exp_v, 2'(kp)}) begin
                    miscompares++;
                    $display("FAIL stall_feed t=%0d: got valid=%b k=%0d want valid=%b k=%0d", t, fv, fk, exp_v, kp);
                end
                for (int r = 0; r < 3; r++) begin
                    exp_a = a_tab[r * 3 + kp];
                    exp_b = (r == kp) ? ONE : 32'h0;
                    vectors++;
                    if (a_out[r] !== exp_a || b_out[r] !== exp_b) begin
                        miscompares++;
                        $display("FAIL stall_operand t=%0d idx=%0d: got a=%h b=%h want a=%h b=%h",
                                 t, r, a_out[r], b_out[r], exp_a, exp_b);
                    end
                end
            end
            if (t >= 20) begin
                vectors++;
                if (fin !== (t == 25)) begin
                    miscompares++;
                    $display("FAIL stall_finish t=%0d: got %b want %b", t, fin, (t == 25));
                end
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_error();
        @(negedge clk);
        start_in = 1'b1;
        for (int t = 1; t <= 26; t++) begin
            @(negedge clk);
            start_in = (t == 5);
            #1;
            vectors++;
            if (err !== (t >= 6)) begin
                miscompares++;
                $display("FAIL error_flag t=%0d: got %b want %b", t, err, (t >= 6));
            end
            if (t >= 20) begin
                vectors++;
                if (fin !== (t == 23)) begin
                    miscompares++;
                    $display("FAIL error_finish t=%0d: got %b want %b", t, fin, (t == 23));
                end
            end
        end
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL error_sticky: got err=%b busy=%b want err=1 busy=0", err, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL error_clear: got %b want 0", err);
        end
    endtask

    task automatic test_reset_midload();
        logic saw_fin = 1'b0;
        @(negedge clk);
        start_in = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            start_in = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if ({busy, fin, err, rd, sel, ri, rj, fv, fk} !== 16'h0 || a_out[0] !== 32'h0 || b_out[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_outputs: got busy=%b rd=%b i=%0d j=%0d sel=%b valid=%b a0=%h want all 0",
                     busy, rd, ri, rj, sel, fv, a_out[0]);
        end
        rst = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            #1;
            if (fin === 1'b1 || busy !== 1'b0) saw_fin = 1'b1;
        end
        vectors++;
        if (saw_fin !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_quiet: got activity=%b want 0", saw_fin);
        end
        start_in = 1'b1;
        for (int t = 1; t <= 23; t++) begin
            @(negedge clk);
            start_in = 1'b0;
            #1;
            if (t == 1) begin
                vectors++;
                if ({rd, sel, ri, rj} !== 8'h80) begin
                    miscompares++;
                    $display("FAIL restart_read: got rd=%b sel=%b i=%0d j=%0d want rd=1 sel=0 i=0 j=0", rd, sel, ri, rj);
                end
            end
            if (t == 20) begin
                vectors++;
                if (a_out[0] !== ONE || b_out[0] !== ONE) begin
                    miscompares++;
                    $display("FAIL restart_operand: got a0=%h b0=%h want %h", a_out[0], b_out[0], ONE);
                end
            end
        end
        vectors++;
        if (fin !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_finish: got %b want 1", fin);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        @(negedge clk);
        start_in = 1'b1;
        for (int t = 1; t <= 48; t++) begin
            @(negedge clk);
            start_in = (t == 24);
            #1;
            vectors++;
            if (fin !== (t == 23 || t == 47)) begin
                miscompares++;
                $display("FAIL b2b_finish t=%0d: got %b want %b", t, fin, (t == 23 || t == 47));
            end
            if (t == 25) begin
                vectors++;
                if ({rd, sel, ri, rj} !== 8'h80) begin
                    miscompares++;
                    $display("FAIL b2b_read: got rd=%b sel=%b i=%0d j=%0d want rd=1 sel=0 i=0 j=0", rd, sel, ri, rj);
                end
            end
            if (t == 44) begin
                vectors++;
                if (fv !== 1'b1 || fk !== 2'd0 || a_out[1] !== a_tab[3]) begin
                    miscompares++;
                    $display("FAIL b2b_feed: got valid=%b k=%0d a1=%h want 1/0/%h", fv, fk, a_out[1], a_tab[3]);
                end
            end
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_error: got %b want 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_error();
        test_reset_midload();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
